// File: rtl/alu_pkg.sv
// Shared ALU op encodings and flag bundle.
// Imported by the ALU pipeline stage and its combinational core.
package alu_pkg;

   localparam int ALU_OP_W = 4;

   localparam logic [ALU_OP_W-1:0] OP_ADD   = 4'd0;
   localparam logic [ALU_OP_W-1:0] OP_SUB   = 4'd1;
   localparam logic [ALU_OP_W-1:0] OP_AND   = 4'd2;
   localparam logic [ALU_OP_W-1:0] OP_OR    = 4'd3;
   localparam logic [ALU_OP_W-1:0] OP_XOR   = 4'd4;
   localparam logic [ALU_OP_W-1:0] OP_SHL   = 4'd5;
   localparam logic [ALU_OP_W-1:0] OP_SHR   = 4'd6;
   localparam logic [ALU_OP_W-1:0] OP_SRA   = 4'd7;
   localparam logic [ALU_OP_W-1:0] OP_SLT   = 4'd8;
   localparam logic [ALU_OP_W-1:0] OP_SLTU  = 4'd9;
   localparam logic [ALU_OP_W-1:0] OP_ADC   = 4'd10;
   localparam logic [ALU_OP_W-1:0] OP_SBB   = 4'd11;
   localparam logic [ALU_OP_W-1:0] OP_PASSB = 4'd12;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   function automatic logic updates_carry(input logic [ALU_OP_W-1:0] op);
      return op inside {OP_ADD, OP_SUB, OP_ADC, OP_SBB};
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, N/Z/C/V flags and illegal-op detect.
// Shift carry is taken from one extra bit beside the operand.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   input  logic [ALU_OP_W-1:0] op,
   input  logic                cin,
   output logic [WIDTH-1:0]    res,
   output flags_t              flags,
   output logic                ill
);

   localparam logic [WIDTH-1:0]   W_VAL  = WIDTH'(WIDTH);
   localparam logic [SHAMT_W:0]   SH_MAX = (SHAMT_W+1)'(WIDTH + 1);

   logic             ci;
   logic             bi;
   logic             far;
   logic [SHAMT_W:0] sh;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH:0]   shl_x;
   logic [WIDTH:0]   shr_x;
   logic [WIDTH:0]   sra_x;

   assign ci   = (op == OP_ADC) & cin;
   assign bi   = (op == OP_SBB) & cin;
   assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
   assign diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};

   // amounts beyond WIDTH saturate to WIDTH+1, which shifts every bit out
   assign far   = b > W_VAL;
   assign sh    = far ? SH_MAX : b[SHAMT_W:0];
   assign shl_x = {1'b0, a} << sh;
   assign shr_x = {a, 1'b0} >> sh;
   assign sra_x = $signed({a, 1'b0}) >>> sh;

   always_comb begin
      res   = '0;
      flags = '0;
      ill   = 1'b0;
      unique case (op)
         OP_ADD, OP_ADC: begin
            res     = sum[WIDTH-1:0];
            flags.c = sum[WIDTH];
            flags.v = (a[WIDTH-1] == b[WIDTH-1]) &&
                      (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB, OP_SBB: begin
            res     = diff[WIDTH-1:0];
            flags.c = diff[WIDTH];
            flags.v = (a[WIDTH-1] != b[WIDTH-1]) &&
                      (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_SHL: begin
            res     = shl_x[WIDTH-1:0];
            flags.c = shl_x[WIDTH];
         end
         OP_SHR: begin
            res     = shr_x[WIDTH:1];
            flags.c = shr_x[0];
         end
         OP_SRA: begin
            res     = sra_x[WIDTH:1];
            flags.c = sra_x[0] & ~far;
         end
         OP_SLT:   res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU:  res = {{(WIDTH-1){1'b0}}, a < b};
         OP_PASSB: res = b;
         default:  ill = 1'b1;
      endcase
      flags.n = res[WIDTH-1];
      flags.z = (res == '0);
   end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU stage between operand fetch and writeback.
// Owns the valid/ready output register and the architectural carry.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    operand1,
   input  logic [WIDTH-1:0]    operand2,
   input  logic [ALU_OP_W-1:0] alu_op,
   input  logic                carry_clr,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    result,
   output logic                zero,
   output logic                negative,
   output logic                carry,
   output logic                overflow,
   output logic                illegal
);

   logic             accept;
   logic             creg;
   logic [WIDTH-1:0] core_res;
   flags_t           core_f;
   logic             core_ill;
   flags_t           flags_q;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   alu_core #(
      .WIDTH  (WIDTH),
      .SHAMT_W(SHAMT_W)
   ) u_core (
      .a    (operand1),
      .b    (operand2),
      .op   (alu_op),
      .cin  (creg),
      .res  (core_res),
      .flags(core_f),
      .ill  (core_ill)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         flags_q   <= '0;
         illegal   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         result    <= core_res;
         flags_q   <= core_f;
         illegal   <= core_ill;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // the core already consumed the pre-clear creg this cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         creg <= 1'b0;
      end else if (carry_clr) begin
         creg <= 1'b0;
      end else if (accept && updates_carry(alu_op)) begin
         creg <= core_f.c;
      end
   end

   assign zero     = flags_q.z;
   assign negative = flags_q.n;
   assign carry    = flags_q.c;
   assign overflow = flags_q.v;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Widths are generic and the op set is extended: XOR, shifts, compares, and carry-chained ADC/SBB.
- Produces a full N/Z/C/V flag set and holds an architectural carry register for multi-word arithmetic.
- Sits between the operand-fetch and writeback stages with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- SHAMT_W, $clog2(WIDTH), shift-amount field width, derived and not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op valid.
- in_ready  output  1  block can accept this cycle.
- operand1  input  WIDTH  A operand.
- operand2  input  WIDTH  B operand / shift amount.
- alu_op  input  4  operation select (alu_pkg encodings).
- carry_clr  input  1  synchronous clear of the carry register.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  downstream accepts.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].
- carry  output  1  carry/borrow of this op.
- overflow  output  1  signed overflow of this op.
- illegal  output  1  alu_op not defined.

Behaviour:
- Reset: rst_n low asynchronously clears out_valid, result, all flags, illegal and the carry register to 0.
  - Reset mid-transaction drops the held result; no output is replayed.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = !out_valid || out_ready.
  - Latency 1: the accepted op appears on result/flags the next cycle with out_valid=1.
  - Full throughput when out_ready is held 1.
  - Outputs are held stable while out_valid && !out_ready.
  - out_valid falls after the handshake unless a new op is accepted in the same cycle.
- Ops (alu_op):
  - 0 ADD: A+B; C=carry-out; V=signed overflow.
  - 1 SUB: A-B; C=borrow (A<B unsigned); V=signed overflow.
  - 2 AND, 3 OR, 4 XOR: C=0, V=0.
  - 5 SHL, 6 SHR (logical), 7 SRA.
    - Amount = operand2 as unsigned.
    - If amount >= WIDTH: SHL/SHR give 0; SRA gives all sign bits.
    - C = last bit shifted out (0 if amount=0, 0 if amount>WIDTH); V=0.
  - 8 SLT: signed compare, result = {0..,A<B}. 9 SLTU: unsigned compare. Both C=0, V=0.
  - 10 ADC: A+B+creg; 11 SBB: A-B-creg. Flags as for ADD/SUB.
  - 12 PASSB: result=B, C=0, V=0.
  - 13-15: result=0, illegal=1, all flags 0 except zero=1; creg unchanged.
- Z and N are always computed from the final result.
- Carry register creg:
  - Updated on acceptance of ops 0,1,10,11 with that op's C.
  - Other ops leave it unchanged.
  - Back-to-back ADC uses the carry of the immediately preceding accepted arithmetic op; no bubble.
  - carry_clr forces creg=0 and wins over an update in the same cycle.
  - An ADC/SBB accepted in that same cycle uses the pre-clear value.
- No accepted op is ever lost or duplicated under any out_ready pattern.

Decomposition:
- alu_pkg:
  - ALU_OP_W=4.
  - Localparam op codes OP_ADD..OP_PASSB.
  - Flags struct (n,z,c,v).
- Sub-module alu_core: purely combinational compute.
  - Inputs: A, B, op, cin. Outputs: result, flags, illegal.
  - alu_pipe owns the handshake, output register and creg.

Test Plan (WIDTH=8):
- Reset: hold rst_n=0 mid-stream -> out_valid=0, result=0x00, creg=0. After release, the first accepted op shows on the next cycle.
- ADD 0xFF+0x01 -> result 0x00, Z=1, C=1, V=0.
  - Then ADC 0x00+0x00 -> 0x01, C=0.
  - ADD 0x7F+0x01 -> 0x80, N=1, V=1.
- SUB 0x10-0x20 -> 0xF0, C=1, N=1.
  - Then SBB 0x05-0x01 -> 0x03.
  - carry_clr with a simultaneous SBB 0x05-0x01 -> 0x03, and creg=0 afterwards.
- Shifts:
  - SHL 0x81 by 1 -> 0x02, C=1.
  - SRA 0x80 by 9 -> 0xFF.
  - SHR 0x80 by 8 -> 0x00, Z=1.
  - SLT 0x80,0x01 -> 0x01; SLTU 0x80,0x01 -> 0x00.
- Backpressure: stream 4 ops with out_ready toggling 0/1 each cycle -> in_ready follows the rule, held outputs are stable, exactly 4 results arrive in order.
- alu_op=14 with A=0x55 -> result 0x00, illegal=1, Z=1; creg is unchanged (checked by a following ADC).
